// File: rtl/clk_div_scheduler.sv
// Programmable clock divider: out_clock = clock / active_div, started/stopped on whole periods only.
// Latency: out_clock/tick change one cycle after enable is sampled; a divisor applies on the next boundary (or next cycle if idle).
// Backpressure: cfg_ready drops while a divisor is pending and rises the cycle after it takes effect.
module clk_div_scheduler #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             out_clock,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] active_div
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             err_q, err_d;
    logic             oclk_q, oclk_d;

    logic             boundary;
    logic             accept;
    logic             cfg_ok;

    // Next-state, phase counter, divisor scheduling and registered output clock level.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;

        boundary = (cnt_q == (div_q - ONE));
        accept   = cfg_valid && !pend_vld_q;
        cfg_ok   = (cfg_div >= TWO);
        err_d    = accept && !cfg_ok;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Nothing is ticking, so a new divisor can take effect immediately.
                if (accept && cfg_ok) begin
                    div_d = cfg_div;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN, STOP: begin
                cnt_d = boundary ? '0 : (cnt_q + ONE);
                // Divisor changes only at a period edge so no period is ever truncated.
                if (boundary && pend_vld_q) begin
                    div_d      = pend_div_q;
                    pend_vld_d = 1'b0;
                end
                // An accept on the boundary itself waits for the following boundary.
                if (accept && cfg_ok) begin
                    pend_vld_d = 1'b1;
                    pend_div_d = cfg_div;
                end
                if (state_q == RUN) begin
                    if (!enable) begin
                        state_d = boundary ? IDLE : STOP;
                    end
                end else begin
                    if (enable) begin
                        state_d = RUN;
                    end else if (boundary) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Computed from next-cycle values so out_clock comes straight from a flop.
        oclk_d = (state_d != IDLE) && (cnt_d < (div_d >> 1));
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DEF_DIV;
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            oclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            oclk_q     <= oclk_d;
        end
    end

    assign running    = (state_q != IDLE);
    assign tick       = running && (cnt_q == '0);
    assign cfg_ready  = !pend_vld_q;
    assign cfg_err    = err_q;
    assign out_clock  = oclk_q;
    assign active_div = div_q;

endmodule

// File: doc/clk_div_scheduler.md
CLK_DIV_SCHEDULER -- requirements
Module: clk_div_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of divisor and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, divisor loaded at reset (legal range 2..2^WIDTH-1).
REQ-003 SHALL have port clock  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  level request to run the divided clock.
REQ-006 SHALL have port cfg_valid  input  1  new divisor offered.
REQ-007 SHALL have port cfg_div  input  WIDTH  offered divisor N.
REQ-008 SHALL have port cfg_ready  output  1  scheduler can accept a divisor.
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse: rejected divisor.
REQ-010 SHALL have port out_clock  output  1  divided clock, driven directly from a flop.
REQ-011 SHALL have port tick  output  1  one-cycle pulse at the first cycle of each output period.
REQ-012 SHALL have port running  output  1  high in RUN or STOP state.
REQ-013 SHALL have port active_div  output  WIDTH  divisor currently in effect.

Function
REQ-014 SHALL implement states IDLE, RUN, STOP; running = (state != IDLE).
REQ-015 SHALL keep phase counter cnt in 0..active_div-1, incrementing each cycle in RUN/STOP; boundary cycle = cnt == active_div-1.
REQ-016 SHALL drive out_clock = 1 while running and cnt < (active_div >> 1), else 0 (even N: 50% duty; odd N: high floor(N/2), low ceil(N/2) cycles).
REQ-017 SHALL assert tick exactly in cycles where running and cnt == 0.
REQ-018 SHALL transition IDLE -> RUN when enable = 1; first RUN cycle has cnt = 0, out_clock = 1, tick = 1.
REQ-019 SHALL transition RUN -> STOP when enable = 0 on a non-boundary cycle; RUN -> IDLE when enable = 0 on a boundary cycle.
REQ-020 SHALL transition STOP -> IDLE on boundary cycle; STOP -> RUN when enable returns to 1 before boundary, counter undisturbed.
REQ-021 SHALL never truncate a period: out_clock low and cnt = 0 in IDLE; no runt pulse on start/stop.
REQ-022 SHALL hold one pending divisor register; cfg_ready = 1 when no pending divisor.
REQ-023 SHALL accept cfg_div on cfg_valid && cfg_ready; cfg_div < 2 is rejected: cfg_err = 1 next cycle, nothing stored, cfg_ready stays 1.
REQ-024 SHALL, in IDLE, apply an accepted divisor to active_div on the following cycle without occupying pending.
REQ-025 SHALL, in RUN/STOP, store an accepted divisor as pending and copy it to active_div on the next boundary cycle, cnt wrapping to 0 under the new divisor; pending clears and cfg_ready rises the cycle after.
REQ-026 SHALL treat an accept coinciding with a boundary cycle as pending for the following boundary.
REQ-027 SHALL, when the last boundary before IDLE has a pending divisor, apply it and enter IDLE in the same cycle.

Reset
REQ-028 SHALL on rst force state IDLE, cnt 0, out_clock 0, tick 0, cfg_err 0, cfg_ready 1, pending cleared, active_div DEFAULT_DIV.
REQ-029 SHALL on rst mid-period drop out_clock to 0 immediately; after release, restart only per REQ-018.

Verification
REQ-030 SHALL verify: reset, enable=1, default N=4 -> out_clock 1,1,0,0 repeating, tick every 4th cycle starting first RUN cycle.
REQ-031 SHALL verify: N=5 in IDLE then enable -> out_clock high 2, low 3 cycles; active_div=5 one cycle after accept.
REQ-032 SHALL verify: while running N=4, offer N=6 at cnt=1 -> cfg_ready low until boundary; next period 6 cycles (3 high/3 low), no short pulse.
REQ-033 SHALL verify: offer cfg_div=1 and 0 -> cfg_err pulses one cycle each, active_div unchanged, cfg_ready stays 1.
REQ-034 SHALL verify: enable dropped at cnt=1 of N=8 -> STOP, period completes 8 cycles, then IDLE with out_clock 0; re-enable in STOP at cnt=3 -> stays running seamlessly.
REQ-035 SHALL verify: rst asserted at cnt=2 of N=6 with pending N=10 -> out_clock 0 asynchronously, active_div=4, pending lost, cfg_ready 1.
